compare_eq_stream: RTL

- Elastic, handshaked equality-compare stage for the streaming datapath.
- Joins two operand streams and compares each pair for equality.
- Emits the result bit together with the in0 operand, so downstream select/filter stages can consume it directly.
- Sits between the producing kernels and the predicate/select stage. It replaces bare combinational compare instances wherever timing closure or backpressure is required.

---
 rtl/tytra_stream_pkg.sv | 15 +
 rtl/compare_eq_stream_cmp.sv | 15 +
 rtl/compare_eq_stream.sv | 138 +++++++++++++
 3 files changed

// File: rtl/tytra_stream_pkg.sv
// Shared definitions for the tytra streaming datapath stages.
//   N_DEFAULT  : default operand word width
//   CW_DEFAULT : default statistics counter width
//   hs_fire()  : handshake transfer helper (valid & ready)
package tytra_stream_pkg;

  localparam int N_DEFAULT  = 10;
  localparam int CW_DEFAULT = 16;

  // A transfer happens on a cycle where both sides agree.
  function automatic logic hs_fire(input logic valid, input logic ready);
    return valid & ready;
  endfunction

endpackage

// File: rtl/compare_eq_stream_cmp.sv
// Combinational equality comparator used between S1 and S2.
// Ports:
//   a, b : N-bit operands, compared as raw unsigned bit vectors
//   eq   : 1 when every bit of a matches b
module compare_eq_stream_cmp #(
  parameter int N = 10
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         eq
);

  assign eq = (a == b);

endmodule

// File: rtl/compare_eq_stream.sv
// Elastic two-stage equality compare: joins the in0/in1 streams, compares
// each pair and emits {eq, in0 operand} with valid/ready backpressure.
// Optional statistics counters are built only when the macro
// COMPARE_EQ_STREAM_CNT_EN is defined; otherwise match_cnt/total_cnt read 0
// and cnt_clr is ignored.
// Ports:
//   clk, rstn                       : clock, asynchronous active-low reset
//   in0_data/in0_valid/in0_ready    : operand A stream
//   in1_data/in1_valid/in1_ready    : operand B stream
//   out_eq/out_data/out_valid/out_ready : result stream (out_data = operand A)
//   cnt_clr                         : synchronous counter clear
//   match_cnt, total_cnt            : saturating result statistics
module compare_eq_stream
  import tytra_stream_pkg::*;
#(
  parameter int N  = N_DEFAULT,
  parameter int CW = CW_DEFAULT
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [N-1:0]  in0_data,
  input  logic          in0_valid,
  output logic          in0_ready,
  input  logic [N-1:0]  in1_data,
  input  logic          in1_valid,
  output logic          in1_ready,
  output logic          out_eq,
  output logic [N-1:0]  out_data,
  output logic          out_valid,
  input  logic          out_ready,
  input  logic          cnt_clr,
  output logic [CW-1:0] match_cnt,
  output logic [CW-1:0] total_cnt
);

  logic         s1_valid;
  logic [N-1:0] s1_a;
  logic [N-1:0] s1_b;
  logic         s2_valid;
  logic         s2_eq;
  logic [N-1:0] s2_a;
  logic         s1_ready;
  logic         s2_ready;
  logic         fire_in;
  logic         cmp_eq;

  // Ready ripples back from the output so a full pipe still moves every
  // cycle the consumer accepts (no bubble on drain+refill).
  assign s2_ready = ~s2_valid | out_ready;
  assign s1_ready = ~s1_valid | s2_ready;

  // Join: each side is only acknowledged when its partner is also present,
  // so a lone operand waits rather than being consumed unpaired.
  assign fire_in   = hs_fire(in0_valid & in1_valid, s1_ready);
  assign in0_ready = s1_ready & in1_valid;
  assign in1_ready = s1_ready & in0_valid;

  compare_eq_stream_cmp #(
    .N (N)
  ) u_cmp (
    .a  (s1_a),
    .b  (s1_b),
    .eq (cmp_eq)
  );

  // Stage 1: capture the joined operand pair.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid <= 1'b0;
      s1_a     <= {N{1'b0}};
      s1_b     <= {N{1'b0}};
    end else if (s1_ready) begin
      s1_valid <= fire_in;
      if (fire_in) begin
        s1_a <= in0_data;
        s1_b <= in1_data;
      end
    end
  end

  // Stage 2: capture the compare result and pass operand A through.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s2_valid <= 1'b0;
      s2_eq    <= 1'b0;
      s2_a     <= {N{1'b0}};
    end else if (s2_ready) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_eq <= cmp_eq;
        s2_a  <= s1_a;
      end
    end
  end

  assign out_valid = s2_valid;
  assign out_eq    = s2_eq;
  assign out_data  = s2_a;

`ifdef COMPARE_EQ_STREAM_CNT_EN
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
  localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

  logic          out_fire;
  logic [CW-1:0] match_q;
  logic [CW-1:0] total_q;

  assign out_fire = hs_fire(s2_valid, out_ready);

  // Saturating statistics; a clear wins over a same-cycle increment.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      match_q <= {CW{1'b0}};
      total_q <= {CW{1'b0}};
    end else if (cnt_clr) begin
      match_q <= {CW{1'b0}};
      total_q <= {CW{1'b0}};
    end else if (out_fire) begin
      if (total_q != CNT_MAX) begin
        total_q <= total_q + CNT_ONE;
      end
      if (s2_eq && (match_q != CNT_MAX)) begin
        match_q <= match_q + CNT_ONE;
      end
    end
  end

  assign match_cnt = match_q;
  assign total_cnt = total_q;
`else
  logic unused_cnt_clr;

  assign unused_cnt_clr = cnt_clr;
  assign match_cnt      = {CW{1'b0}};
  assign total_cnt      = {CW{1'b0}};
`endif

endmodule
